// File: rtl/led_display_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package led_display_pkg;

    typedef enum logic {
        SHOW,
        GAP
    } t_scan_state;

    localparam int NUM_DIGITS         = 4;
    localparam int DEFAULT_GAP_CYCLES = 2;

    function automatic logic [3:0] digit_nibble(input logic [15:0] v, input logic [1:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    // Digit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic digit_blanked(input logic [15:0] v, input logic [1:0] idx,
                                           input logic blz);
        logic b;
        case (idx)
            2'd1:    b = blz && (v[15:4] == 12'h000);
            2'd2:    b = blz && (v[15:8] == 8'h00);
            2'd3:    b = blz && (v[15:12] == 4'h0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/led_display_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner with dark inter-digit gaps,
// leading-zero blanking and frame-aligned value updates via load/ack.
//
// state | meaning
// ------+----------------------------------------------------------------
// SHOW  | digit digit_idx driven (unless blanked) for divider+1 clocks
// GAP   | all digits dark for GAP_CYCLES clocks before the next digit
module led_display_scanner
    import led_display_pkg::*;
#(
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divider,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    output logic        ack,
    output logic [3:0]  hex,
    output logic [3:0]  digit_enable,
    output logic        dp
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    t_scan_state     state, state_n;
    logic [1:0]      digit_idx, idx_n;
    logic [15:0]     count, count_n;
    logic [15:0]     display_reg, disp_n;
    logic [NUM_DIGITS-1:0] dp_reg, dpr_n;
    logic            blz_reg, blz_n;
    logic [15:0]     pending_value;
    logic [NUM_DIGITS-1:0] pending_dp;
    logic            pending_blz;
    logic            pending_valid;
    logic            transfer;
    logic            accept;
    logic            lit_n;

    always_comb begin
        state_n  = state;
        idx_n    = digit_idx;
        count_n  = count;
        disp_n   = display_reg;
        dpr_n    = dp_reg;
        blz_n    = blz_reg;
        transfer = 1'b0;

        case (state)
            SHOW: begin
                if (count == 16'd0) begin
                    state_n = GAP;
                    count_n = GAP_LOAD;
                end else begin
                    count_n = count - 16'd1;
                end
            end
            GAP: begin
                if (count == 16'd0) begin
                    state_n  = SHOW;
                    idx_n    = 2'(digit_idx + 2'd1);
                    count_n  = divider;
                    transfer = (idx_n == 2'd0) && pending_valid;
                end else begin
                    count_n = count - 16'd1;
                end
            end
            default: begin
                state_n = GAP;
                count_n = 16'd0;
            end
        endcase

        // New value lands on the same edge digit 0 starts, so frames never mix.
        if (transfer) begin
            disp_n = pending_value;
            dpr_n  = pending_dp;
            blz_n  = pending_blz;
        end

        accept = load && !pending_valid;
        lit_n  = (state_n == SHOW) && !digit_blanked(disp_n, idx_n, blz_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= GAP;
            digit_idx     <= 2'd3;
            count         <= 16'd0;
            display_reg   <= 16'd0;
            dp_reg        <= '0;
            blz_reg       <= 1'b0;
            pending_value <= 16'd0;
            pending_dp    <= '0;
            pending_blz   <= 1'b0;
            pending_valid <= 1'b0;
            ack           <= 1'b0;
            hex           <= 4'd0;
            digit_enable  <= 4'd0;
            dp            <= 1'b0;
        end else begin
            state       <= state_n;
            digit_idx   <= idx_n;
            count       <= count_n;
            display_reg <= disp_n;
            dp_reg      <= dpr_n;
            blz_reg     <= blz_n;

            if (transfer) begin
                pending_valid <= 1'b0;
            end else if (accept) begin
                pending_valid <= 1'b1;
                pending_value <= value;
                pending_dp    <= dp_mask;
                pending_blz   <= blank_lz;
            end

            ack          <= accept;
            hex          <= digit_nibble(disp_n, idx_n);
            digit_enable <= lit_n ? (4'b0001 << idx_n) : 4'b0000;
            dp           <= lit_n && dpr_n[idx_n];
        end
    end

endmodule

// File: tb/tb_led_display_scanner.sv
// Randomised scoreboard bench for led_display_scanner against a slot-level reference model.
module tb_led_display_scanner;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] divider = 16'd3;
    logic        load = 1'b0;
    logic [15:0] value = 16'd0;
    logic [3:0]  dp_mask = 4'd0;
    logic        blank_lz = 1'b0;
    logic        ack;
    logic [3:0]  hex;
    logic [3:0]  digit_enable;
    logic        dp;

    int checks = 0;
    int passes = 0;

    led_display_scanner #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .divider(divider), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .ack(ack), .hex(hex),
        .digit_enable(digit_enable), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] hex;
        logic [3:0] en;
        logic       dp;
    } out_t;

    typedef struct {
        out_t o;
        logic ack;
    } exp_t;

    out_t slot_q[$];
    exp_t sb_q[$];

    logic [15:0] m_disp = 16'd0, m_pval = 16'd0;
    logic [3:0]  m_dp = 4'd0, m_pdp = 4'd0;
    logic        m_blz = 1'b0, m_pblz = 1'b0, m_pv = 1'b0;
    int          m_next_digit = 0;

    // A digit is dark when blanking is on and nothing non-zero sits at or above it.
    function automatic bit model_blanked(int d, logic [15:0] v, logic b);
        return b && d > 0 && ((int'(v) >> (4 * d)) == 0);
    endfunction

    task automatic model_reset();
        m_disp = 0; m_dp = 0; m_blz = 0;
        m_pv = 0; m_next_digit = 0;
        slot_q.delete();
        sb_q.delete();
    endtask

    // Reference model: whenever the slot schedule runs dry a new digit slot begins.
    always @(posedge clk) begin
        if (!reset) begin
            bit   acc, xfer;
            int   d;
            out_t o;
            exp_t e;
            acc  = load && !m_pv;
            xfer = 0;
            if (slot_q.size() == 0) begin
                d = m_next_digit;
                xfer = (d == 0) && m_pv;
                if (xfer) begin
                    m_disp = m_pval; m_dp = m_pdp; m_blz = m_pblz;
                end
                o.hex = 4'((int'(m_disp) >> (4 * d)) % 16);
                if (model_blanked(d, m_disp, m_blz)) begin
                    o.en = 4'd0; o.dp = 1'b0;
                end else begin
                    o.en = 4'(1 << d); o.dp = m_dp[d];
                end
                for (int i = 0; i <= int'(divider); i++) slot_q.push_back(o);
                o.en = 4'd0; o.dp = 1'b0;
                for (int i = 0; i < GAP; i++) slot_q.push_back(o);
                m_next_digit = (d + 1) % 4;
            end
            if (xfer) m_pv = 0;
            if (acc) begin
                m_pv = 1; m_pval = value; m_pdp = dp_mask; m_pblz = blank_lz;
            end
            e.o   = slot_q.pop_front();
            e.ack = acc;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        checks++;
        if (reset) begin
            if (hex == 0 && digit_enable == 0 && dp == 0 && ack == 0) passes++;
            else $display("FAIL reset_hold t=%0t got hex=%h en=%b dp=%b ack=%b want all zero",
                          $time, hex, digit_enable, dp, ack);
        end else if (sb_q.size() == 0) begin
            $display("FAIL sb_empty t=%0t no expected entry for outputs", $time);
        end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (hex == e.o.hex && digit_enable == e.o.en && dp == e.o.dp && ack == e.ack)
                passes++;
            else
                $display("FAIL cycle t=%0t got hex=%h en=%b dp=%b ack=%b want hex=%h en=%b dp=%b ack=%b",
                         $time, hex, digit_enable, dp, ack, e.o.hex, e.o.en, e.o.dp, e.ack);
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge on which ack is seen.
    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic b,
                           input bit drop);
        bit got;
        got = 0;
        load = 1'b1; value = v; dp_mask = m; blank_lz = b;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL ack_timeout t=%0t got no ack want ack within 500 cycles", $time);
        end
        if (drop || !got) load = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic reset_mid_scan();
        bit seen;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (digit_enable == 4'b0100) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL wait_digit2 t=%0t got en=%b want 0100 within 500 cycles",
                     $time, digit_enable);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (hex == 0 && digit_enable == 0 && dp == 0 && ack == 0) passes++;
        else $display("FAIL async_reset t=%0t got hex=%h en=%b dp=%b ack=%b want all zero",
                      $time, hex, digit_enable, dp, ack);
        model_reset();
        idle(2);
        release_reset();
    endtask

    initial begin
        logic [15:0] masks [5];
        masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
        masks[3] = 16'h000F; masks[4] = 16'h0000;

        idle(3);
        release_reset();
        idle(60);

        idle(7);
        do_load(16'h1234, 4'b0100, 1'b0, 1);
        idle(50);

        do_load(16'h5678, 4'b0001, 1'b0, 0);
        do_load(16'hABCD, 4'b1010, 1'b0, 1);
        idle(80);

        do_load(16'h0042, 4'b1111, 1'b1, 1);
        idle(50);
        do_load(16'h0000, 4'b1111, 1'b1, 1);
        idle(50);
        do_load(16'h0402, 4'b0100, 1'b1, 1);
        idle(30);

        reset_mid_scan();
        idle(40);

        idle(5);
        divider = 16'd0;
        idle(40);

        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                divider = 16'($urandom_range(0, 5));
                idle($urandom_range(1, 8));
            end else if (r < 4) begin
                do_load(16'($urandom) & masks[$urandom_range(0, 4)], 4'($urandom),
                        1'($urandom), 1);
            end else if (r == 4) begin
                do_load(16'($urandom), 4'($urandom), 1'($urandom), 0);
                do_load(16'($urandom) & masks[$urandom_range(0, 4)], 4'($urandom),
                        1'($urandom), 1);
            end else begin
                idle($urandom_range(1, 10));
            end
        end
        idle(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
